// File: rtl/io_cnt_pkg.sv
// Shared definitions for the I/O-queue counter dump collector.
// Latency: n/a (constants, types and elaboration-time helpers only).
// Backpressure: n/a.
package io_cnt_pkg;

    // Counter type codes carried in the 2-bit type field of each record
    localparam logic [1:0] CNT_STALL = 2'd0;
    localparam logic [1:0] CNT_READ  = 2'd1;
    localparam logic [1:0] CNT_EMPTY = 2'd2;
    localparam logic [1:0] CNT_FULL  = 2'd3;

    // Port numbering used by the leaves: inputs start at 2, outputs at 9, stall is port 0
    localparam int OUTPUT_PORT_MIN_NUM = 9;
    localparam int INPUT_PORT_BASE     = 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } coll_state_e;

    // Stored record is {leaf, port, type, val}
    function automatic int calc_rec_w(input int leaf_bits, input int port_bits,
                                      input int payload_bits);
        return leaf_bits + port_bits + 2 + payload_bits;
    endfunction

    // Input queues report read/empty/full, output queues report full/empty
    function automatic int calc_expected(input int in_ports, input int out_ports,
                                         input int stall_cnt);
        return in_ports * 3 + out_ports * 2 + stall_cnt;
    endfunction

endpackage

// File: rtl/cnt_rec_fifo.sv
// First-word-fall-through record buffer; head entry drives rd_dat combinationally.
// Latency: a word pushed at edge t is visible on rd_dat from t+1 when the buffer was empty.
// Backpressure: a push while full is accepted only if a pop happens in the same cycle.
//
// Ports: clk_user, reset_user_n (async active-low); push/wr_dat write side;
//        pop/rd_dat read side (rd_dat is 0 while empty); full, empty, level status.
module cnt_rec_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk_user,
    input  logic                   reset_user_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers carry one wrap bit so full and empty are distinguishable
    always_ff @(posedge clk_user or negedge reset_user_n) begin
        if (!reset_user_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: rd_dat is masked while empty
    always_ff @(posedge clk_user) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_dat;
    end

    assign level  = wr_ptr - rd_ptr;
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/io_queue_cnt_collector.sv
// Captures per-leaf counter dump streams as frames, buffers records for host readout.
// Latency: record visible on rd_* one cycle after capture; frame_done one cycle after last record.
// Backpressure: none toward the leaf; records arriving while the buffer is full are dropped and counted.
//
// Ports: clk_user, reset_user_n (async active-low); cnt_* record input stream;
//        rd_valid/rd_ready/rd_* FWFT host read port, fifo_level occupancy;
//        frame_done/frame_err/frame_leaf/frame_rec_cnt last-frame report; drop_cnt total drops.
module io_queue_cnt_collector
    import io_cnt_pkg::*;
#(
    parameter int NUM_LEAF_BITS = 6,
    parameter int NUM_PORT_BITS = 4,
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_IN_PORTS  = 7,
    parameter int NUM_OUT_PORTS = 7,
    parameter int STALL_CNT     = 0,
    parameter int FIFO_DEPTH    = 64
) (
    input  logic                         clk_user,
    input  logic                         reset_user_n,
    input  logic                         cnt_valid,
    input  logic [NUM_LEAF_BITS-1:0]     cnt_leaf,
    input  logic [NUM_PORT_BITS-1:0]     cnt_port,
    input  logic [1:0]                   cnt_type,
    input  logic [PAYLOAD_BITS-1:0]      cnt_val,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [NUM_LEAF_BITS-1:0]     rd_leaf,
    output logic [NUM_PORT_BITS-1:0]     rd_port,
    output logic [1:0]                   rd_type,
    output logic [PAYLOAD_BITS-1:0]      rd_val,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         frame_done,
    output logic                         frame_err,
    output logic [NUM_LEAF_BITS-1:0]     frame_leaf,
    output logic [7:0]                   frame_rec_cnt,
    output logic [15:0]                  drop_cnt
);
    localparam int REC_W    = calc_rec_w(NUM_LEAF_BITS, NUM_PORT_BITS, PAYLOAD_BITS);
    localparam int EXPECTED = calc_expected(NUM_IN_PORTS, NUM_OUT_PORTS, STALL_CNT);

    coll_state_e              state;
    coll_state_e              state_nxt;
    logic [7:0]               rec_cnt;
    logic [NUM_LEAF_BITS-1:0] leaf_cap;
    logic                     mismatch;
    logic                     drop_seen;

    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     push;
    logic                     pop;
    logic                     drop;
    logic [REC_W-1:0]         wr_dat;
    logic [REC_W-1:0]         rd_dat;

    // A pop frees a slot in the same cycle, so a full buffer still accepts a record then
    assign pop    = rd_valid && rd_ready;
    assign push   = cnt_valid && (!fifo_full || pop);
    assign drop   = cnt_valid && fifo_full && !pop;
    assign wr_dat = {cnt_leaf, cnt_port, cnt_type, cnt_val};

    cnt_rec_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_user     (clk_user),
        .reset_user_n (reset_user_n),
        .push         (push),
        .wr_dat       (wr_dat),
        .pop          (pop),
        .rd_dat       (rd_dat),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .level        (fifo_level)
    );

    assign rd_valid = !fifo_empty;
    assign {rd_leaf, rd_port, rd_type, rd_val} = rd_dat;

    always_ff @(posedge clk_user or negedge reset_user_n) begin
        if (!reset_user_n) state <= ST_IDLE;
        else               state <= state_nxt;
    end

    // A contiguous high run of cnt_valid is one frame
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (cnt_valid)  state_nxt = ST_RECV;
            ST_RECV: if (!cnt_valid) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_user or negedge reset_user_n) begin
        if (!reset_user_n) begin
            rec_cnt       <= '0;
            leaf_cap      <= '0;
            mismatch      <= 1'b0;
            drop_seen     <= 1'b0;
            frame_done    <= 1'b0;
            frame_err     <= 1'b0;
            frame_leaf    <= '0;
            frame_rec_cnt <= '0;
            drop_cnt      <= '0;
        end else begin
            frame_done <= 1'b0;
            if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
            case (state)
                ST_IDLE: begin
                    if (cnt_valid) begin
                        rec_cnt   <= 8'd1;
                        leaf_cap  <= cnt_leaf;
                        mismatch  <= 1'b0;
                        drop_seen <= drop;
                    end
                end
                ST_RECV: begin
                    if (cnt_valid) begin
                        if (rec_cnt != 8'hFF) rec_cnt <= rec_cnt + 8'd1;
                        if (cnt_leaf != leaf_cap) mismatch <= 1'b1;
                        if (drop) drop_seen <= 1'b1;
                    end else begin
                        frame_done    <= 1'b1;
                        frame_leaf    <= leaf_cap;
                        frame_rec_cnt <= rec_cnt;
                        frame_err     <= (32'(rec_cnt) != EXPECTED) || mismatch || drop_seen;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
